// File: rtl/conway_pkg.sv
// Shared types for the Conway board storage and its reader.
package conway_pkg;

  // Scan sequencer states for grid_row_reader
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEND   = 2'd1,
    FINISH = 2'd2
  } reader_state_t;

endpackage : conway_pkg

// File: rtl/dff.sv
// Board register array: write-enabled register with async active-low reset.
module dff #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_we,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  // Load on write enable, clear on reset
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_q <= '0;
    end else if (i_we) begin
      o_q <= i_d;
    end
  end

endmodule : dff

// File: rtl/row_popcount.sv
// Combinational live-cell count of one board row.
module row_popcount #(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0]         i_row,
  output logic [$clog2(WIDTH+1)-1:0] o_count
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);

  // Sum every cell bit into a count wide enough for an all-live row
  always_comb begin
    o_count = '0;
    for (int unsigned c = 0; c < WIDTH; c++) begin
      o_count = o_count + CNT_W'(i_row[c]);
    end
  end

endmodule : row_popcount

// File: rtl/grid_row_reader.sv
// Snapshots the board and streams it one row per valid/ready transfer,
// reporting per-row and whole-board live-cell counts.
module grid_row_reader
  import conway_pkg::*;
#(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned HEIGHT = 8
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                start,
  input  logic [WIDTH*HEIGHT-1:0]             board,
  input  logic                                ready,
  output logic                                valid,
  output logic [WIDTH-1:0]                    row_data,
  output logic [$clog2(HEIGHT)-1:0]           row_idx,
  output logic [$clog2(WIDTH+1)-1:0]          row_count,
  output logic                                busy,
  output logic                                done,
  output logic [$clog2(WIDTH*HEIGHT+1)-1:0]   total_count
);

  localparam int unsigned IDX_W = $clog2(HEIGHT);
  localparam int unsigned TOT_W = $clog2(WIDTH * HEIGHT + 1);

  reader_state_t               r_state;
  logic [TOT_W-1:0]            r_acc;
  logic [WIDTH*HEIGHT-1:0]     w_snap;
  logic [WIDTH-1:0]            w_next_row;
  logic                        w_snap_we;

  // Capture only when a scan is actually accepted
  assign w_snap_we = start && (r_state == IDLE);

  dff #(
    .WIDTH (WIDTH * HEIGHT)
  ) u_snapshot (
    .i_clk   (clk),
    .i_rst_n (reset),
    .i_we    (w_snap_we),
    .i_d     (board),
    .o_q     (w_snap)
  );

  row_popcount #(
    .WIDTH (WIDTH)
  ) u_row_popcount (
    .i_row   (row_data),
    .o_count (row_count)
  );

  // Select the snapshot row following the one currently presented
  always_comb begin
    w_next_row = '0;
    for (int unsigned r = 0; r < HEIGHT; r++) begin
      if (32'(row_idx) + 32'd1 == 32'(r)) begin
        w_next_row = w_snap[r*WIDTH +: WIDTH];
      end
    end
  end

  // Scan sequencer with registered handshake, row and count outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= IDLE;
      r_acc       <= '0;
      valid       <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      row_idx     <= '0;
      row_data    <= '0;
      total_count <= '0;
    end else begin
      done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            // Row 0 comes straight from board since the snapshot loads on this same edge
            r_state     <= SEND;
            valid       <= 1'b1;
            busy        <= 1'b1;
            row_idx     <= '0;
            row_data    <= board[WIDTH-1:0];
            r_acc       <= '0;
            total_count <= '0;
          end
        end
        SEND: begin
          if (ready) begin
            r_acc <= r_acc + TOT_W'(row_count);
            if (row_idx == IDX_W'(HEIGHT - 1)) begin
              r_state     <= FINISH;
              valid       <= 1'b0;
              done        <= 1'b1;
              total_count <= r_acc + TOT_W'(row_count);
            end else begin
              row_idx  <= row_idx + IDX_W'(1);
              row_data <= w_next_row;
            end
          end
        end
        FINISH: begin
          r_state <= IDLE;
          busy    <= 1'b0;
        end
        default: begin
          r_state <= IDLE;
          valid   <= 1'b0;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule : grid_row_reader

// File: tb/tb_grid_row_reader.sv
// Self-checking bench for grid_row_reader (4x4 board).
module tb_grid_row_reader;

  localparam int W = 4;
  localparam int H = 4;

  logic        clk;
  logic        reset;
  logic        start;
  logic [15:0] board;
  logic        ready;
  logic        valid;
  logic [3:0]  row_data;
  logic [1:0]  row_idx;
  logic [2:0]  row_count;
  logic        busy;
  logic        done;
  logic [4:0]  total_count;

  int n_checks = 0;
  int n_errors = 0;

  grid_row_reader #(
    .WIDTH  (W),
    .HEIGHT (H)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .board       (board),
    .ready       (ready),
    .valid       (valid),
    .row_data    (row_data),
    .row_idx     (row_idx),
    .row_count   (row_count),
    .busy        (busy),
    .done        (done),
    .total_count (total_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: row k of the scan is bits [k*W +: W] of the board captured at start;
  // counts are plain bit counts. mode 0: ready always, 1: random ready,
  // 2: three stalls while row 1 is presented. poke: stray start pulses.
  task automatic run_scan(input logic [15:0] b, input int mode, input bit poke);
    int k;
    int stalls;
    int edges;
    int tot;
    bit rdy;
    logic [3:0] exp_row;
    k = 0;
    stalls = 0;
    edges = 0;
    tot = $countones(b);
    board = b;
    start = 1'b1;
    step();
    start = 1'b0;
    board = ~b;
    chk("busy_on", 32'(busy), 32'd1);
    while (k < H && edges < 200) begin
      exp_row = b[k*W +: W];
      chk("valid", 32'(valid), 32'd1);
      chk("row_idx", 32'(row_idx), 32'(k));
      chk("row_data", 32'(row_data), 32'(exp_row));
      chk("row_count", 32'(row_count), 32'($countones(exp_row)));
      chk("done_low", 32'(done), 32'd0);
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = ($urandom_range(0, 2) != 0);
        default: rdy = !(k == 1 && stalls < 3);
      endcase
      ready = rdy;
      start = poke && ($urandom_range(0, 2) == 0);
      board = 16'($urandom);
      step();
      edges++;
      if (rdy) k++;
      else stalls++;
    end
    start = 1'b0;
    ready = 1'b0;
    if (k != H) chk("timeout", 32'(k), 32'(H));
    chk("done", 32'(done), 32'd1);
    chk("valid_off", 32'(valid), 32'd0);
    chk("busy_fin", 32'(busy), 32'd1);
    chk("total", 32'(total_count), 32'(tot));
    // start during the done cycle must be ignored
    start = poke;
    board = 16'($urandom);
    step();
    start = 1'b0;
    chk("done_pulse", 32'(done), 32'd0);
    chk("busy_off", 32'(busy), 32'd0);
    chk("valid_idle", 32'(valid), 32'd0);
    chk("total_hold", 32'(total_count), 32'(tot));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0;
    start = 1'b0;
    ready = 1'b0;
    board = '0;
    #23;
    chk("rst_valid", 32'(valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_row_data", 32'(row_data), 32'd0);
    chk("rst_row_count", 32'(row_count), 32'd0);
    chk("rst_total", 32'(total_count), 32'd0);
    step();
    reset = 1'b1;
    step();

    // Reset mid-scan on a full board
    board = 16'hFFFF;
    start = 1'b1;
    ready = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    chk("mid_row_idx", 32'(row_idx), 32'd2);
    reset = 1'b0;
    #1;
    chk("abort_valid", 32'(valid), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_row_idx", 32'(row_idx), 32'd0);
    chk("abort_row_data", 32'(row_data), 32'd0);
    chk("abort_row_count", 32'(row_count), 32'd0);
    chk("abort_total", 32'(total_count), 32'd0);
    step();
    chk("abort_no_done", 32'(done), 32'd0);
    reset = 1'b1;
    ready = 1'b0;
    step();
    chk("abort_idle_done", 32'(done), 32'd0);

    run_scan(16'h8421, 0, 1'b0);
    run_scan(16'hF0F3, 2, 1'b0);
    run_scan(16'h0000, 0, 1'b0);
    run_scan(16'hA5C3, 0, 1'b1);
    run_scan(16'hFFFF, 0, 1'b0);
    for (int i = 0; i < 20; i++) begin
      run_scan(16'($urandom), 1, 1'($urandom_range(0, 1)));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule : tb_grid_row_reader
